// File: rtl/rs_table_if.sv
// Reservation-station payload types and the dispatch/CDB/issue bundle around rs_table.
// Optional build macro honoured by rs_table: RS_FREE_BYPASS_EN.

package rs_table_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ROB_ADDR_BITS = 5;
  localparam int unsigned OP_W          = 4;
  localparam int unsigned DEST_W        = 5;

  // Instruction payload carried from dispatch through the RS to issue
  typedef struct packed {
    logic                     valid;
    logic [OP_W-1:0]          op;
    logic [DEST_W-1:0]        dest;
    logic [ROB_ADDR_BITS-1:0] rob_tag;
    logic [XLEN-1:0]          rs1_value;
    logic [XLEN-1:0]          rs2_value;
  } rs_is_packet_t;

endpackage

interface rs_table_if #(
  parameter int unsigned WIDTH = 16
) ();

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic                                   squash;

  logic                                   dp_valid;
  rs_table_pkg::rs_is_packet_t            dp_packet;
  logic [rs_table_pkg::ROB_ADDR_BITS-1:0] dp_src1_tag;
  logic                                   dp_src1_rdy;
  logic [rs_table_pkg::ROB_ADDR_BITS-1:0] dp_src2_tag;
  logic                                   dp_src2_rdy;
  logic                                   dp_ready;

  logic                                   cdb_valid;
  logic [rs_table_pkg::ROB_ADDR_BITS-1:0] cdb_tag;
  logic [rs_table_pkg::XLEN-1:0]          cdb_value;

  logic [WIDTH-1:0]                       free;
  logic [WIDTH-1:0]                       req;
  rs_table_pkg::rs_is_packet_t            rs_is_packet_out [WIDTH];
  logic [CNT_W-1:0]                       num_free;

  // Dispatch / CDB / issue side driving the table
  modport master (
    output squash,
    output dp_valid, dp_packet, dp_src1_tag, dp_src1_rdy, dp_src2_tag, dp_src2_rdy,
    input  dp_ready,
    output cdb_valid, cdb_tag, cdb_value,
    output free,
    input  req, rs_is_packet_out, num_free
  );

  // The reservation-station table itself
  modport slave (
    input  squash,
    input  dp_valid, dp_packet, dp_src1_tag, dp_src1_rdy, dp_src2_tag, dp_src2_rdy,
    output dp_ready,
    input  cdb_valid, cdb_tag, cdb_value,
    input  free,
    output req, rs_is_packet_out, num_free
  );

endinterface

// File: rtl/rs_table.sv
// Reservation-station entry storage: allocates dispatched instructions into the lowest empty
// slot, wakes pending operands from the CDB, exposes per-entry issue requests and packets, and
// releases entries selected by issue.
// Build option: define RS_FREE_BYPASS_EN to let entries being freed this cycle be reallocated
// in the same cycle (and count as empty for dp_ready/num_free).

module rs_table
  import rs_table_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  rs_table_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned TAG_W = ROB_ADDR_BITS;

  // Registered entry state
  logic [WIDTH-1:0] valid_q;
  logic [WIDTH-1:0] src1_rdy_q;
  logic [WIDTH-1:0] src2_rdy_q;
  logic [TAG_W-1:0] src1_tag_q [WIDTH];
  logic [TAG_W-1:0] src2_tag_q [WIDTH];
  rs_is_packet_t    pkt_q      [WIDTH];

  // Next-state values
  logic [WIDTH-1:0] valid_d;
  logic [WIDTH-1:0] src1_rdy_d;
  logic [WIDTH-1:0] src2_rdy_d;
  logic [TAG_W-1:0] src1_tag_d [WIDTH];
  logic [TAG_W-1:0] src2_tag_d [WIDTH];
  rs_is_packet_t    pkt_d      [WIDTH];

  // Allocation helpers
  logic [WIDTH-1:0] empty;
  logic [WIDTH-1:0] alloc_oh;
  logic             alloc_en;
  logic [CNT_W-1:0] free_cnt;

  // Dispatch-side operand capture, including a same-cycle CDB hit
  logic          dp_src1_hit;
  logic          dp_src2_hit;
  rs_is_packet_t dp_pkt;

`ifdef RS_FREE_BYPASS_EN
  // Entries being released this cycle are already treated as empty
  assign empty = ~valid_q | bus.free;
`else
  // Only entries invalid in the register are empty
  assign empty = ~valid_q;
`endif

  assign bus.dp_ready = |empty;
  assign bus.num_free = free_cnt;
  assign bus.req      = valid_q & src1_rdy_q & src2_rdy_q;
  assign alloc_en     = bus.dp_valid & bus.dp_ready & ~bus.squash;

  assign dp_src1_hit = bus.cdb_valid & ~bus.dp_src1_rdy & (bus.cdb_tag == bus.dp_src1_tag);
  assign dp_src2_hit = bus.cdb_valid & ~bus.dp_src2_rdy & (bus.cdb_tag == bus.dp_src2_tag);

  // Build the packet written on allocation so a broadcast in the dispatch cycle is never missed
  always_comb begin
    dp_pkt       = bus.dp_packet;
    dp_pkt.valid = 1'b1;
    if (dp_src1_hit) begin
      dp_pkt.rs1_value = bus.cdb_value;
    end
    if (dp_src2_hit) begin
      dp_pkt.rs2_value = bus.cdb_value;
    end
  end

  // Lowest-index empty entry wins the dispatch
  always_comb begin
    logic found;
    alloc_oh = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (empty[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Count of entries available for dispatch
  always_comb begin
    free_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      free_cnt = free_cnt + CNT_W'(empty[i]);
    end
  end

  // Per-entry next state: release, CDB wakeup, allocation, then squash overrides all
  always_comb begin
    valid_d    = valid_q;
    src1_rdy_d = src1_rdy_q;
    src2_rdy_d = src2_rdy_q;
    src1_tag_d = src1_tag_q;
    src2_tag_d = src2_tag_q;
    pkt_d      = pkt_q;

    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.free[i]) begin
        valid_d[i] = 1'b0;
      end

      if (valid_q[i] && bus.cdb_valid && !src1_rdy_q[i] && (src1_tag_q[i] == bus.cdb_tag)) begin
        pkt_d[i].rs1_value = bus.cdb_value;
        src1_rdy_d[i]      = 1'b1;
      end

      if (valid_q[i] && bus.cdb_valid && !src2_rdy_q[i] && (src2_tag_q[i] == bus.cdb_tag)) begin
        pkt_d[i].rs2_value = bus.cdb_value;
        src2_rdy_d[i]      = 1'b1;
      end

      if (alloc_en && alloc_oh[i]) begin
        valid_d[i]    = 1'b1;
        pkt_d[i]      = dp_pkt;
        src1_tag_d[i] = bus.dp_src1_tag;
        src2_tag_d[i] = bus.dp_src2_tag;
        src1_rdy_d[i] = bus.dp_src1_rdy | dp_src1_hit;
        src2_rdy_d[i] = bus.dp_src2_rdy | dp_src2_hit;
      end
    end

    if (bus.squash) begin
      valid_d = '0;
    end
  end

  // Entry registers; reset clears every entry immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
        pkt_q[i]      <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      src1_rdy_q <= src1_rdy_d;
      src2_rdy_q <= src2_rdy_d;
      src1_tag_q <= src1_tag_d;
      src2_tag_q <= src2_tag_d;
      pkt_q      <= pkt_d;
    end
  end

  // Issue-facing packets; the valid field always mirrors the entry's valid bit
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bus.rs_is_packet_out[i]       = pkt_q[i];
      bus.rs_is_packet_out[i].valid = valid_q[i];
    end
  end

endmodule

// File: tb/tb_rs_table.sv
// Directed scoreboard bench for rs_table: expectations are queued as stimulus is driven and
// popped against DUT outputs once they are due.

module tb_rs_table;

  import rs_table_pkg::*;

  localparam int unsigned WIDTH = 16;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sbq [$];

  rs_table_if #(.WIDTH(WIDTH)) bus ();

  rs_table #(.WIDTH(WIDTH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.squash      = 1'b0;
    bus.dp_valid    = 1'b0;
    bus.dp_packet   = '0;
    bus.dp_src1_tag = '0;
    bus.dp_src1_rdy = 1'b0;
    bus.dp_src2_tag = '0;
    bus.dp_src2_rdy = 1'b0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
    bus.free        = '0;
  endtask

  task automatic dispatch(input logic [4:0] rob, input logic [4:0] t1, input logic r1,
                          input logic [31:0] v1, input logic [4:0] t2, input logic r2,
                          input logic [31:0] v2);
    rs_is_packet_t pk;
    pk.valid        = 1'b1;
    pk.op           = 4'h1;
    pk.dest         = rob;
    pk.rob_tag      = rob;
    pk.rs1_value    = v1;
    pk.rs2_value    = v2;
    bus.dp_valid    = 1'b1;
    bus.dp_packet   = pk;
    bus.dp_src1_tag = t1;
    bus.dp_src1_rdy = r1;
    bus.dp_src2_tag = t2;
    bus.dp_src2_rdy = r2;
  endtask

  task automatic broadcast(input logic [4:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    #2;
    exp("rst_req", 64'h0);
    exp("rst_num_free", 64'd16);
    exp("rst_dp_ready", 64'd1);
    chk(64'(bus.req));
    chk(64'(bus.num_free));
    chk(64'(bus.dp_ready));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Fill all 16 entries with ready instructions; a 17th is refused
    for (int i = 0; i < 16; i++) begin
      dispatch(5'(i), 5'd0, 1'b1, 32'(i), 5'd0, 1'b1, 32'(100 + i));
      tick();
    end
    dispatch(5'd16, 5'd0, 1'b1, 32'h16, 5'd0, 1'b1, 32'h16);
    exp("full_dp_ready", 64'd0);
    chk(64'(bus.dp_ready));
    tick();
    idle();
    #1;
    exp("full_req", 64'hFFFF);
    exp("full_num_free", 64'd0);
    exp("full_entry15_rob", 64'd15);
    exp("full_entry0_rob", 64'd0);
    exp("full_entry0_rs2", 64'd100);
    chk(64'(bus.req));
    chk(64'(bus.num_free));
    chk(64'(bus.rs_is_packet_out[15].rob_tag));
    chk(64'(bus.rs_is_packet_out[0].rob_tag));
    chk(64'(bus.rs_is_packet_out[0].rs2_value));

    // Release entries 5..15, leaving five valid
    bus.free = 16'hFFE0;
    tick();
    idle();
    #1;
    exp("free_req", 64'h001F);
    exp("free_num_free", 64'd11);
    chk(64'(bus.req));
    chk(64'(bus.num_free));

    // Asynchronous reset mid-cycle, no clock edge in between
    rst = 1'b1;
    #1;
    exp("async_rst_req", 64'h0);
    exp("async_rst_num_free", 64'd16);
    exp("async_rst_dp_ready", 64'd1);
    exp("async_rst_pkt0_valid", 64'd0);
    chk(64'(bus.req));
    chk(64'(bus.num_free));
    chk(64'(bus.dp_ready));
    chk(64'(bus.rs_is_packet_out[0].valid));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // CDB wakeup of a pending src1 in entry 3
    for (int i = 0; i < 3; i++) begin
      dispatch(5'(i), 5'd0, 1'b1, 32'(i), 5'd0, 1'b1, 32'(i));
      tick();
    end
    dispatch(5'd3, 5'd5, 1'b0, 32'h0, 5'd0, 1'b1, 32'h33);
    tick();
    idle();
    #1;
    exp("pending_req", 64'h0007);
    chk(64'(bus.req));
    broadcast(5'd5, 32'h1234);
    tick();
    idle();
    #1;
    exp("wake_req", 64'h000F);
    exp("wake_rs1", 64'h1234);
    exp("wake_rs2_kept", 64'h33);
    chk(64'(bus.req));
    chk(64'(bus.rs_is_packet_out[3].rs1_value));
    chk(64'(bus.rs_is_packet_out[3].rs2_value));

    // Dispatch-cycle wakeup of src2 into entry 4
    dispatch(5'd4, 5'd0, 1'b1, 32'h44, 5'd7, 1'b0, 32'h0);
    broadcast(5'd7, 32'hBEEF);
    tick();
    idle();
    #1;
    exp("dp_wake_req", 64'h001F);
    exp("dp_wake_rs2", 64'hBEEF);
    chk(64'(bus.req));
    chk(64'(bus.rs_is_packet_out[4].rs2_value));

    // Both sources woken by one broadcast
    dispatch(5'd5, 5'd9, 1'b0, 32'h0, 5'd9, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    exp("both_pending_req", 64'h001F);
    chk(64'(bus.req));
    broadcast(5'd9, 32'hCAFE);
    tick();
    idle();
    #1;
    exp("both_wake_req", 64'h003F);
    exp("both_wake_rs1", 64'hCAFE);
    exp("both_wake_rs2", 64'hCAFE);
    chk(64'(bus.req));
    chk(64'(bus.rs_is_packet_out[5].rs1_value));
    chk(64'(bus.rs_is_packet_out[5].rs2_value));

    // Fill remaining entries, then free entry 4 while dispatching
    for (int i = 6; i < 16; i++) begin
      dispatch(5'(i), 5'd0, 1'b1, 32'(i), 5'd0, 1'b1, 32'(i));
      tick();
    end
    idle();
    #1;
    exp("refill_dp_ready", 64'd0);
    chk(64'(bus.dp_ready));
    bus.free = 16'h0010;
    dispatch(5'd20, 5'd0, 1'b1, 32'h20, 5'd0, 1'b1, 32'h20);
    #1;
`ifdef RS_FREE_BYPASS_EN
    exp("bypass_dp_ready", 64'd1);
    exp("bypass_num_free", 64'd1);
`else
    exp("nobypass_dp_ready", 64'd0);
    exp("nobypass_num_free", 64'd0);
`endif
    chk(64'(bus.dp_ready));
    chk(64'(bus.num_free));
    tick();
    idle();
    #1;
`ifdef RS_FREE_BYPASS_EN
    exp("bypass_req", 64'hFFFF);
    exp("bypass_entry4_rob", 64'd20);
    exp("bypass_num_free_after", 64'd0);
    chk(64'(bus.req));
    chk(64'(bus.rs_is_packet_out[4].rob_tag));
    chk(64'(bus.num_free));
`else
    exp("nobypass_req", 64'hFFEF);
    exp("nobypass_num_free_after", 64'd1);
    exp("nobypass_dp_ready_after", 64'd1);
    chk(64'(bus.req));
    chk(64'(bus.num_free));
    chk(64'(bus.dp_ready));
`endif

    // Clear everything, load 8 entries, then squash alongside dispatch/free/wakeup
    bus.free = 16'hFFFF;
    tick();
    idle();
    #1;
    exp("free_all_num_free", 64'd16);
    chk(64'(bus.num_free));
    for (int i = 0; i < 8; i++) begin
      dispatch(5'(i), 5'd0, 1'b1, 32'(i), 5'd0, 1'b1, 32'(i));
      tick();
    end
    idle();
    #1;
    exp("eight_req", 64'h00FF);
    chk(64'(bus.req));
    dispatch(5'd30, 5'd0, 1'b1, 32'h30, 5'd0, 1'b1, 32'h30);
    bus.squash = 1'b1;
    bus.free   = 16'h0001;
    broadcast(5'd3, 32'h5555);
    tick();
    idle();
    #1;
    exp("squash_req", 64'h0);
    exp("squash_num_free", 64'd16);
    exp("squash_dp_ready", 64'd1);
    chk(64'(bus.req));
    chk(64'(bus.num_free));
    chk(64'(bus.dp_ready));
    dispatch(5'd1, 5'd0, 1'b1, 32'h1, 5'd0, 1'b1, 32'h1);
    tick();
    idle();
    #1;
    exp("post_squash_req", 64'h0001);
    exp("post_squash_rob", 64'd1);
    chk(64'(bus.req));
    chk(64'(bus.rs_is_packet_out[0].rob_tag));

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
